// File: rtl/csr_unit_irq.sv
// csr_unit_irq: machine-mode CSR unit with interrupt pending/enable logic.
//
// Implements mstatus, misa, mie, mtvec, mscratch, mepc, mcause, mtval, mip
// and the 64-bit mcycle/minstret counters, together with trap entry, mret
// and interrupt prioritisation for the trap controller.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   raddr/rdata/rd_illegal     combinational CSR read port
//   waddr/wdata/csr_w/
//   csr_wsc_mode               CSR write port (01 write, 10 set, 11 clear)
//   trap, mepc_in, mcause_in,
//   mtval_in                   trap entry
//   mret                       return from trap
//   irq_ext/irq_sw/irq_timer/
//   irq_local                  level-sensitive interrupt sources
//   instr_retire               retirement strobe for minstret
//   irq_pending/irq_cause      highest-priority enabled interrupt
//   trap_target                next PC for a trap
//   mepc_out/mstatus_out       current mepc / mstatus
module csr_unit_irq #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] raddr,
    output logic [31:0] rdata,
    output logic        rd_illegal,
    input  logic [11:0] waddr,
    input  logic [31:0] wdata,
    input  logic        csr_w,
    input  logic [1:0]  csr_wsc_mode,
    input  logic        trap,
    input  logic        mret,
    input  logic [31:0] mepc_in,
    input  logic [31:0] mcause_in,
    input  logic [31:0] mtval_in,
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic        irq_timer,
    input  logic [((NUM_IRQ > 0) ? NUM_IRQ : 1)-1:0] irq_local,
    input  logic        instr_retire,
    output logic        irq_pending,
    output logic [31:0] irq_cause,
    output logic [31:0] trap_target,
    output logic [31:0] mepc_out,
    output logic [31:0] mstatus_out
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;

    localparam logic [31:0] MISA_VAL   = 32'h4000_0100;
    localparam logic [31:0] LOCAL_MASK = 32'(((64'd1 << NUM_IRQ) - 64'd1) << 16);
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | LOCAL_MASK;
    localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

    logic        st_mie;
    logic        st_mpie;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [31:0] mip_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic [31:0] mstatus_val;
    logic [31:0] mip_next;
    logic [32:0] rd_lookup;
    logic [32:0] wr_lookup;
    logic [31:0] w_new;
    logic        wr_en;
    logic [31:0] pend;
    logic [4:0]  irq_code;
    logic        irq_any;

    // MPP is hard-wired to 11; only MIE and MPIE are state.
    assign mstatus_val = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};

    function automatic logic [32:0] csr_lookup(input logic [11:0] a);
        case (a)
            A_MSTATUS:  return {1'b0, mstatus_val};
            A_MISA:     return {1'b0, MISA_VAL};
            A_MIE:      return {1'b0, mie_q};
            A_MTVEC:    return {1'b0, mtvec_q};
            A_MSCRATCH: return {1'b0, mscratch_q};
            A_MEPC:     return {1'b0, mepc_q};
            A_MCAUSE:   return {1'b0, mcause_q};
            A_MTVAL:    return {1'b0, mtval_q};
            A_MIP:      return {1'b0, mip_q};
            A_MCYCLE:   return {1'b0, mcycle_q[31:0]};
            A_MINSTRET: return {1'b0, minstret_q[31:0]};
            A_MCYCLEH:  return {1'b0, mcycle_q[63:32]};
            A_MINSTRH:  return {1'b0, minstret_q[63:32]};
            default:    return {1'b1, 32'h0};
        endcase
    endfunction

    always_comb begin
        rd_lookup  = csr_lookup(raddr);
        rdata      = rd_lookup[31:0];
        rd_illegal = rd_lookup[32];
    end

    // Old value for set/clear comes from the same view the read port exposes.
    always_comb begin
        wr_lookup = csr_lookup(waddr);
        case (csr_wsc_mode)
            2'b10:   w_new = wr_lookup[31:0] | wdata;
            2'b11:   w_new = wr_lookup[31:0] & ~wdata;
            default: w_new = wdata;
        endcase
    end

    assign wr_en = csr_w && !trap && !mret;

    always_comb begin
        mip_next     = '0;
        mip_next[3]  = irq_sw;
        mip_next[7]  = irq_timer;
        mip_next[11] = irq_ext;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            mip_next[16+i] = irq_local[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
        end else begin
            mip_q <= mip_next;
            if (trap) begin
                mepc_q   <= mepc_in & ~32'h3;
                mcause_q <= mcause_in;
                mtval_q  <= mtval_in;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else if (mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (wr_en) begin
                case (waddr)
                    A_MSTATUS: begin
                        st_mie  <= w_new[3];
                        st_mpie <= w_new[7];
                    end
                    A_MIE:      mie_q      <= w_new & MIE_MASK;
                    A_MTVEC:    mtvec_q    <= w_new & MTVEC_MASK;
                    A_MSCRATCH: mscratch_q <= w_new;
                    A_MEPC:     mepc_q     <= w_new & ~32'h3;
                    A_MCAUSE:   mcause_q   <= w_new;
                    A_MTVAL:    mtval_q    <= w_new;
                    default: ;
                endcase
            end
        end
    end

    // A write to either counter half replaces it and skips that cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (wr_en && waddr == A_MCYCLE)
                mcycle_q[31:0] <= w_new;
            else if (wr_en && waddr == A_MCYCLEH)
                mcycle_q[63:32] <= w_new;
            else
                mcycle_q <= mcycle_q + 64'd1;

            if (wr_en && waddr == A_MINSTRET)
                minstret_q[31:0] <= w_new;
            else if (wr_en && waddr == A_MINSTRH)
                minstret_q[63:32] <= w_new;
            else if (instr_retire)
                minstret_q <= minstret_q + 64'd1;
        end
    end

    // Priority: MEI > MSI > MTI > local lines, lowest index first.
    always_comb begin
        pend     = mip_q & mie_q;
        irq_code = '0;
        irq_any  = 1'b0;
        if (pend[11]) begin
            irq_code = 5'd11;
            irq_any  = 1'b1;
        end else if (pend[3]) begin
            irq_code = 5'd3;
            irq_any  = 1'b1;
        end else if (pend[7]) begin
            irq_code = 5'd7;
            irq_any  = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                if (!irq_any && pend[16+i]) begin
                    irq_code = 5'(16 + i);
                    irq_any  = 1'b1;
                end
            end
        end
    end

    assign irq_pending = st_mie && irq_any;
    assign irq_cause   = irq_any ? {1'b1, 26'b0, irq_code} : 32'h0;

    always_comb begin
        if (mtvec_q[0] && mcause_in[31])
            trap_target = (mtvec_q & ~32'h3) + {25'b0, mcause_in[4:0], 2'b00};
        else
            trap_target = mtvec_q & ~32'h3;
    end

    assign mepc_out    = mepc_q;
    assign mstatus_out = mstatus_val;

endmodule

// File: tb/tb_csr_unit_irq.sv
module tb_csr_unit_irq;
    localparam int unsigned NIRQ = 4;
    localparam logic [31:0] MTR  = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] raddr, waddr;
    logic [31:0] rdata, wdata;
    logic        rd_illegal, csr_w, trap, mret, instr_retire;
    logic [1:0]  csr_wsc_mode;
    logic [31:0] mepc_in, mcause_in, mtval_in;
    logic        irq_ext, irq_sw, irq_timer;
    logic [NIRQ-1:0] irq_local;
    logic        irq_pending;
    logic [31:0] irq_cause, trap_target, mepc_out, mstatus_out;

    int unsigned checks = 0;
    int unsigned errors = 0;

    csr_unit_irq #(.NUM_IRQ(NIRQ), .MTVEC_RESET(MTR), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rd_illegal(rd_illegal),
        .waddr(waddr), .wdata(wdata), .csr_w(csr_w), .csr_wsc_mode(csr_wsc_mode),
        .trap(trap), .mret(mret), .mepc_in(mepc_in), .mcause_in(mcause_in), .mtval_in(mtval_in),
        .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_local(irq_local),
        .instr_retire(instr_retire), .irq_pending(irq_pending), .irq_cause(irq_cause),
        .trap_target(trap_target), .mepc_out(mepc_out), .mstatus_out(mstatus_out)
    );

    always #5 clk = ~clk;

    // Reference model: architectural CSR state
    bit          m_mieb, m_mpie;
    logic [31:0] m_mie, m_mtvec, m_msc, m_mepc, m_mcause, m_mtval, m_mip;
    logic [63:0] m_cyc, m_ins;

    task automatic m_reset();
        m_mieb = 0; m_mpie = 0; m_mie = 0; m_mtvec = MTR; m_msc = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0; m_cyc = 0; m_ins = 0;
    endtask

    function automatic logic [32:0] mread(input logic [11:0] a);
        case (a)
            12'h300: return {1'b0, 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mieb ? 32'h8 : 32'h0)};
            12'h301: return {1'b0, 32'h4000_0100};
            12'h304: return {1'b0, m_mie};
            12'h305: return {1'b0, m_mtvec};
            12'h340: return {1'b0, m_msc};
            12'h341: return {1'b0, m_mepc};
            12'h342: return {1'b0, m_mcause};
            12'h343: return {1'b0, m_mtval};
            12'h344: return {1'b0, m_mip};
            12'hB00: return {1'b0, m_cyc[31:0]};
            12'hB02: return {1'b0, m_ins[31:0]};
            12'hB80: return {1'b0, m_cyc[63:32]};
            12'hB82: return {1'b0, m_ins[63:32]};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic logic [31:0] m_cause();
        logic [31:0] p;
        p = m_mip & m_mie;
        if (p[11]) return 32'h8000_000B;
        if (p[3])  return 32'h8000_0003;
        if (p[7])  return 32'h8000_0007;
        for (int i = 0; i < NIRQ; i++)
            if (p[16+i]) return 32'h8000_0000 + 32'(16 + i);
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] base;
        base = m_mtvec & ~32'h3;
        if (m_mtvec[0] && mcause_in[31]) return base + 32'd4 * 32'(mcause_in[4:0]);
        return base;
    endfunction

    task automatic mstep();
        logic [32:0] r;
        logic [31:0] v;
        bit cw, iw;
        cw = 0; iw = 0;
        if (trap) begin
            m_mepc = mepc_in & ~32'h3; m_mcause = mcause_in; m_mtval = mtval_in;
            m_mpie = m_mieb; m_mieb = 0;
        end else if (mret) begin
            m_mieb = m_mpie; m_mpie = 1;
        end else if (csr_w) begin
            r = mread(waddr);
            case (csr_wsc_mode)
                2'b10:   v = r[31:0] | wdata;
                2'b11:   v = r[31:0] & ~wdata;
                default: v = wdata;
            endcase
            case (waddr)
                12'h300: begin m_mieb = v[3]; m_mpie = v[7]; end
                12'h304: m_mie = v & (32'h888 | (((32'd1 << NIRQ) - 1) << 16));
                12'h305: m_mtvec = v & ~32'h2;
                12'h340: m_msc = v;
                12'h341: m_mepc = v & ~32'h3;
                12'h342: m_mcause = v;
                12'h343: m_mtval = v;
                12'hB00: begin m_cyc[31:0]  = v; cw = 1; end
                12'hB80: begin m_cyc[63:32] = v; cw = 1; end
                12'hB02: begin m_ins[31:0]  = v; iw = 1; end
                12'hB82: begin m_ins[63:32] = v; iw = 1; end
                default: ;
            endcase
        end
        if (!cw) m_cyc = m_cyc + 1;
        if (!iw && instr_retire) m_ins = m_ins + 1;
        m_mip = 0;
        m_mip[3] = irq_sw; m_mip[7] = irq_timer; m_mip[11] = irq_ext;
        for (int i = 0; i < NIRQ; i++) m_mip[16+i] = irq_local[i];
    endtask

    task automatic step();
        mstep();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [1:0] mode);
        csr_w = 1; waddr = a; wdata = d; csr_wsc_mode = mode;
        step();
        csr_w = 0;
    endtask

    task automatic clear_inputs();
        raddr = 0; waddr = 0; wdata = 0; csr_w = 0; csr_wsc_mode = 2'b01;
        trap = 0; mret = 0; mepc_in = 0; mcause_in = 0; mtval_in = 0;
        irq_ext = 0; irq_sw = 0; irq_timer = 0; irq_local = 0; instr_retire = 0;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [14] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0};
        logic [31:0] exps  [14] = '{32'h1800, 32'h4000_0100, 0, MTR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        clear_inputs();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        m_reset();
        trap = 1; mepc_in = 32'h1000; mcause_in = 32'h5;
        step();
        checks++;
        if (mepc_out !== 32'h1000) begin
            errors++; $display("FAIL pre_reset_trap mepc got %h want %h", mepc_out, 32'h1000);
        end
        mepc_in = 32'h3000;
        #2 rst_n = 0;
        #1;
        checks++;
        if (mepc_out !== 32'h0 || mstatus_out !== 32'h1800) begin
            errors++; $display("FAIL async_reset mepc %h mstatus %h want 0 / 1800", mepc_out, mstatus_out);
        end
        @(posedge clk); #1;
        clear_inputs();
        m_reset();
        checks++;
        if (mepc_out !== 32'h0 || mcause_in !== 32'h0 || irq_pending !== 1'b0 || irq_cause !== 32'h0) begin
            errors++; $display("FAIL reset_outputs mepc %h pend %b cause %h", mepc_out, irq_pending, irq_cause);
        end
        checks++;
        if (trap_target !== MTR) begin
            errors++; $display("FAIL reset_trap_target got %h want %h", trap_target, MTR);
        end
        for (int i = 0; i < 14; i++) begin
            raddr = addrs[i];
            #1;
            checks++;
            if (rdata !== exps[i] || rd_illegal !== (i == 13)) begin
                errors++;
                $display("FAIL reset_read addr %h got %h/%b want %h/%b", addrs[i], rdata, rd_illegal, exps[i], i == 13);
            end
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_mtvec();
        do_write(12'h305, 32'h8000_0003, 2'b01);
        raddr = 12'h305; #1;
        checks++;
        if (rdata !== 32'h8000_0001) begin
            errors++; $display("FAIL mtvec_warl got %h want %h", rdata, 32'h8000_0001);
        end
        mcause_in = 32'h8000_000B; #1;
        checks++;
        if (trap_target !== 32'h8000_002C) begin
            errors++; $display("FAIL vectored_target got %h want %h", trap_target, 32'h8000_002C);
        end
        mcause_in = 32'h2; #1;
        checks++;
        if (trap_target !== 32'h8000_0000) begin
            errors++; $display("FAIL exception_target got %h want %h", trap_target, 32'h8000_0000);
        end
        mcause_in = 0;
    endtask

    task automatic test_warl();
        do_write(12'h300, 32'hFFFF_FFFF, 2'b01);
        checks++;
        if (mstatus_out !== 32'h1888) begin
            errors++; $display("FAIL mstatus_warl_set got %h want %h", mstatus_out, 32'h1888);
        end
        do_write(12'h300, 32'hFFFF_FFFF, 2'b11);
        checks++;
        if (mstatus_out !== 32'h1800) begin
            errors++; $display("FAIL mstatus_warl_clr got %h want %h", mstatus_out, 32'h1800);
        end
        do_write(12'h304, 32'hFFFF_FFFF, 2'b00);
        raddr = 12'h304; #1;
        checks++;
        if (rdata !== 32'h000F_0888) begin
            errors++; $display("FAIL mie_warl got %h want %h", rdata, 32'h000F_0888);
        end
        do_write(12'h341, 32'hFFFF_FFFF, 2'b01);
        checks++;
        if (mepc_out !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL mepc_warl got %h want %h", mepc_out, 32'hFFFF_FFFC);
        end
        do_write(12'h301, 32'h0, 2'b01);
        do_write(12'h344, 32'hFFFF_FFFF, 2'b01);
        raddr = 12'h301; #1;
        checks++;
        if (rdata !== 32'h4000_0100) begin
            errors++; $display("FAIL misa_ro got %h want %h", rdata, 32'h4000_0100);
        end
        raddr = 12'h344; #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL mip_ro got %h want 0", rdata);
        end
        do_write(12'h304, 32'h0, 2'b01);
    endtask

    task automatic test_irq();
        do_write(12'h300, 32'h8, 2'b10);
        do_write(12'h304, 32'h888, 2'b01);
        irq_timer = 1; irq_ext = 1; #1;
        checks++;
        if (irq_pending !== 1'b0) begin
            errors++; $display("FAIL irq_latency pend got %b want 0", irq_pending);
        end
        step();
        checks++;
        if (irq_pending !== 1'b1 || irq_cause !== 32'h8000_000B) begin
            errors++; $display("FAIL irq_mei pend %b cause %h want 1 / 8000000b", irq_pending, irq_cause);
        end
        irq_ext = 0; #1;
        checks++;
        if (irq_cause !== 32'h8000_000B) begin
            errors++; $display("FAIL irq_hold cause %h want 8000000b", irq_cause);
        end
        step();
        checks++;
        if (irq_cause !== 32'h8000_0007) begin
            errors++; $display("FAIL irq_mti cause %h want 80000007", irq_cause);
        end
        irq_timer = 0; irq_local = 4'b0110;
        do_write(12'h304, 32'h0006_0000, 2'b01);
        checks++;
        if (irq_pending !== 1'b1 || irq_cause !== 32'h8000_0011) begin
            errors++; $display("FAIL irq_local pend %b cause %h want 1 / 80000011", irq_pending, irq_cause);
        end
        irq_sw = 1;
        do_write(12'h304, 32'h8, 2'b10);
        checks++;
        if (irq_cause !== 32'h8000_0003) begin
            errors++; $display("FAIL irq_msi cause %h want 80000003", irq_cause);
        end
        do_write(12'h300, 32'h8, 2'b11);
        checks++;
        if (irq_pending !== 1'b0) begin
            errors++; $display("FAIL irq_masked pend %b want 0", irq_pending);
        end
        irq_sw = 0; irq_local = 0;
        do_write(12'h300, 32'h8, 2'b10);
    endtask

    task automatic test_trap_mret();
        trap = 1; mepc_in = 32'h1236; mcause_in = 32'h8000_000B; mtval_in = 32'h55;
        step();
        trap = 0; mcause_in = 0;
        checks++;
        if (mepc_out !== 32'h1234 || mstatus_out !== 32'h1880) begin
            errors++; $display("FAIL trap_entry mepc %h mstatus %h want 1234 / 1880", mepc_out, mstatus_out);
        end
        raddr = 12'h342; #1;
        checks++;
        if (rdata !== 32'h8000_000B) begin
            errors++; $display("FAIL trap_mcause got %h want 8000000b", rdata);
        end
        raddr = 12'h343; #1;
        checks++;
        if (rdata !== 32'h55) begin
            errors++; $display("FAIL trap_mtval got %h want 55", rdata);
        end
        mret = 1;
        step();
        mret = 0;
        checks++;
        if (mepc_out !== 32'h1234 || mstatus_out !== 32'h1888) begin
            errors++; $display("FAIL mret mepc %h mstatus %h want 1234 / 1888", mepc_out, mstatus_out);
        end
    endtask

    task automatic test_priority();
        do_write(12'h340, 32'h5A5A, 2'b01);
        raddr = 12'h340;
        csr_w = 1; waddr = 12'h340; wdata = 32'hFFFF; csr_wsc_mode = 2'b01;
        trap = 1; mepc_in = 32'h2000; mcause_in = 32'h2;
        #1;
        checks++;
        if (rdata !== 32'h5A5A) begin
            errors++; $display("FAIL rdw_old got %h want 5a5a", rdata);
        end
        step();
        trap = 0; mcause_in = 0;
        checks++;
        if (rdata !== 32'h5A5A || mepc_out !== 32'h2000 || mstatus_out !== 32'h1880) begin
            errors++; $display("FAIL trap_over_write msc %h mepc %h mstatus %h want 5a5a/2000/1880", rdata, mepc_out, mstatus_out);
        end
        mret = 1; waddr = 12'h300; wdata = 32'h80; csr_wsc_mode = 2'b11;
        step();
        mret = 0;
        checks++;
        if (mstatus_out !== 32'h1888) begin
            errors++; $display("FAIL mret_over_write mstatus %h want 1888", mstatus_out);
        end
        waddr = 12'h340; wdata = 32'hFFFF; csr_wsc_mode = 2'b01;
        step();
        csr_w = 0;
        checks++;
        if (rdata !== 32'hFFFF) begin
            errors++; $display("FAIL write_visible got %h want ffff", rdata);
        end
    endtask

    task automatic test_counters();
        instr_retire = 0;
        do_write(12'hB00, 32'hFFFF_FFFF, 2'b01);
        do_write(12'hB80, 32'h0, 2'b01);
        raddr = 12'hB00; #1;
        checks++;
        if (rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL mcycle_write got %h want ffffffff", rdata);
        end
        step(); step();
        raddr = 12'hB80; #1;
        checks++;
        if (rdata !== 32'h1) begin
            errors++; $display("FAIL mcycleh_carry got %h want 1", rdata);
        end
        raddr = 12'hB00; #1;
        checks++;
        if (rdata !== 32'h1) begin
            errors++; $display("FAIL mcycle_after got %h want 1", rdata);
        end
        do_write(12'hB82, 32'hFFFF_FFFF, 2'b01);
        do_write(12'hB02, 32'hFFFF_FFFF, 2'b01);
        instr_retire = 1;
        step();
        instr_retire = 0;
        raddr = 12'hB02; #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL minstret_wrap got %h want 0", rdata);
        end
        raddr = 12'hB82; #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL minstreth_wrap got %h want 0", rdata);
        end
    endtask

    task automatic test_random();
        logic [11:0] pool [15] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                   12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0, 12'h000};
        logic [32:0] r;
        for (int n = 0; n < 400; n++) begin
            raddr        = pool[$urandom_range(0, 14)];
            csr_w        = ($urandom_range(0, 1) == 1);
            waddr        = pool[$urandom_range(0, 14)];
            wdata        = $urandom;
            csr_wsc_mode = 2'($urandom);
            trap         = ($urandom_range(0, 15) == 0);
            mret         = ($urandom_range(0, 15) == 0);
            mepc_in      = $urandom;
            mcause_in    = $urandom_range(0, 1) ? {1'b1, 31'($urandom_range(0, 31))} : $urandom;
            mtval_in     = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                irq_ext = 1'($urandom); irq_sw = 1'($urandom); irq_timer = 1'($urandom);
                irq_local = 4'($urandom);
            end
            instr_retire = 1'($urandom);
            #1;
            r = mread(raddr);
            checks++;
            if (rdata !== r[31:0] || rd_illegal !== r[32]) begin
                errors++; $display("FAIL rand_read n=%0d addr %h got %h/%b want %h/%b", n, raddr, rdata, rd_illegal, r[31:0], r[32]);
            end
            checks++;
            if (irq_pending !== (m_mieb && (m_mip & m_mie) != 0) || irq_cause !== m_cause()) begin
                errors++; $display("FAIL rand_irq n=%0d got %b/%h want %b/%h", n, irq_pending, irq_cause, m_mieb && (m_mip & m_mie) != 0, m_cause());
            end
            checks++;
            if (trap_target !== m_target() || mepc_out !== m_mepc || mstatus_out !== mread(12'h300)) begin
                errors++; $display("FAIL rand_state n=%0d tgt %h mepc %h mst %h want %h/%h/%h", n, trap_target, mepc_out, mstatus_out, m_target(), m_mepc, mread(12'h300));
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_mtvec();
        test_warl();
        test_irq();
        test_trap_mret();
        test_priority();
        test_counters();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_unit_irq.md
Name: csr_unit_irq

Overview:
Parametrised machine-mode CSR unit, successor to the current CSR register file in the core. It adds interrupt pending/enable logic with NUM_IRQ local lines, 64-bit mcycle/minstret counters, WARL masking and vectored mtvec, and it corrects mret semantics. It sits beside the ID/EX stage. The pipeline reads CSRs, issues csrrw/s/c writes, and the trap controller consumes irq_pending/trap_target.

Parameters:
NUM_IRQ, 4, local interrupt lines; line i maps to mip/mie bit 16+i; legal range 0..16
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
VECTORED_EN, 1, 1 = mtvec mode 1 is honoured; 0 = mode bit reads 0 and is not writable

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
raddr  in  12  CSR read address
rdata  out  32  CSR read data, combinational
rd_illegal  out  1  raddr is not an implemented CSR
waddr  in  12  CSR write address
wdata  in  32  write operand
csr_w  in  1  CSR write enable
csr_wsc_mode  in  2  01 write, 10 set, 11 clear, 00 treated as write
trap  in  1  take trap this cycle
mret  in  1  execute mret this cycle
mepc_in  in  32  trapping PC
mcause_in  in  32  trap cause; bit31 = interrupt
mtval_in  in  32  trap value
irq_ext, irq_sw, irq_timer  in  1 each  level-sensitive MEIP/MSIP/MTIP sources
irq_local  in  NUM_IRQ  level-sensitive local sources
instr_retire  in  1  one instruction retired this cycle
irq_pending  out  1  interrupt must be taken
irq_cause  out  32  mcause value for the highest-priority pending interrupt
trap_target  out  32  next PC for a trap
mepc_out  out  32  mepc
mstatus_out  out  32  mstatus

Behaviour:
- Implemented CSRs: mstatus 300, misa 301, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, mcycle B00, minstret B02, mcycleh B80, minstreth B82.
- Any other raddr: rdata=0, rd_illegal=1. A write to an unimplemented or read-only CSR is ignored.
- Reset (rst_n low, async) values:
  - mstatus=32'h0000_1800 (MPP=11, MIE=0, MPIE=0)
  - mtvec=MTVEC_RESET
  - all other registers, counters and the mip latch = 0
  - all outputs derive from these values.
- misa is read-only: 32'h4000_0100 (RV32I).
- Write data: new = wdata | old&~0 per mode, i.e. write = wdata, set = old|wdata, clear = old&~wdata. WARL masks are then applied:
  - mstatus: only bits 3 and 7 are writable; MPP always reads 11.
  - mie: only bits 3, 7, 11 and 16..16+NUM_IRQ-1 are writable.
  - mtvec: bit1 is forced to 0; bit0 is forced to 0 when VECTORED_EN=0.
  - mepc: bits[1:0] are forced to 0.
  - mip is read-only.
- Update priority per cycle: trap > mret > csr_w. The lower-priority events are dropped that cycle.
- trap:
  - mepc<=mepc_in&~3, mcause<=mcause_in, mtval<=mtval_in
  - MPIE<=MIE, MIE<=0, MPP stays 11.
- mret: MIE<=MPIE, MPIE<=1. No other CSR changes.
- mip latch:
  - Registered once per cycle: bit3=irq_sw, bit7=irq_timer, bit11=irq_ext, bit16+i=irq_local[i].
  - Reads return this registered value, so an input change is visible one cycle later.
- Interrupt output (combinational from registered state):
  - irq_pending = MIE & |(mip & mie).
  - Priority: MEI(11) > MSI(3) > MTI(7) > local, lowest index first.
  - irq_cause = 32'h8000_0000 | code; 0 when nothing is pending.
- trap_target:
  - If mtvec[0]=1 and mcause_in[31]=1: (mtvec & ~3) + 4*mcause_in[4:0].
  - Otherwise: mtvec & ~3.
- Counters:
  - 64-bit; mcycle +1 every cycle; minstret +1 when instr_retire.
  - Wrap from all-ones to 0.
  - A CSR write to either half replaces that half with the written value and suppresses the increment that cycle; the other half is unchanged.
- Read-during-write: rdata returns the old value. The new value is visible the next cycle.
- rst_n asserted mid-trap: reset wins immediately; there is no partial update.

Test Plan:
- Reset, then read every CSR. Required: mstatus=0x1800, misa=0x40000100, mtvec=MTVEC_RESET, all others 0. Unimplemented address 0x7C0: rdata=0, rd_illegal=1.
- csrrw 0x305 wdata=0x80000003, VECTORED_EN=1. Required: mtvec reads 0x80000001. Then trap with mcause_in=0x8000000B: trap_target=0x8000002C. Exception with mcause_in=2: trap_target=0x80000000.
- Set MIE=1, mie=0x888, then raise irq_timer and irq_ext in the same cycle. Required: the next cycle gives irq_pending=1 and irq_cause=0x8000000B. Drop irq_ext: irq_cause becomes 0x80000007 one cycle later.
- Trap with mepc_in=0x1236 and MIE=1. Required: mepc=0x1234, MIE=0, MPIE=1. Then mret: MIE=1, MPIE=1, mepc unchanged.
- trap and csr_w to mscratch in the same cycle. Required: mscratch unchanged and trap effects applied.
- Write mcycle=0xFFFFFFFF and mcycleh=0. Required: two cycles later mcycleh=1 and mcycle=1. Write minstreth=0xFFFFFFFF and minstret=0xFFFFFFFF, then retire one instruction: both halves read 0.
